// File: rtl/yarvi_uart_tx.sv
// yarvi_uart_tx: byte-stream to 8N1 UART transmitter.
// Bytes accepted on the in_valid/in_ready handshake are queued in a small FIFO
// and sent LSB first behind a start bit and followed by one stop bit. The
// frame FSM pops the next byte on the same edge a stop bit ends, so queued
// bytes go out with no idle gap between frames.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (txd low) for one bit period
//   DATA  | eight data bits, LSB first, one bit period each
//   STOP  | stop bit (txd high); next byte popped at its end if one is queued
module yarvi_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_LOG2    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        sh_q;
    logic              txd_q;

    logic [7:0]        mem_q [DEPTH];
    logic [FIFO_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2:0] rd_ptr_q, rd_ptr_d;

    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              baud_tc;
    logic [7:0]        head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                        (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
    assign head       = mem_q[rd_ptr_q[FIFO_LOG2-1:0]];

    assign baud_tc = (baud_q == BAUD_LAST);

    // Full refuses even when a pop happens this edge, keeping in_ready a pure
    // function of registered pointers.
    assign push = in_valid && !fifo_full;
    assign pop  = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_tc));

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    assign in_ready = !fifo_full;
    assign txd      = txd_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

    // FIFO storage write port; contents need no reset since pointers gate reads.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= in_data;
        end
    end

    // FIFO pointers; reset discards anything still queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Frame sequencer: baud timing, shift register and registered txd.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        sh_q    <= head;
                        baud_q  <= '0;
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_tc) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= sh_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            sh_q  <= {1'b0, sh_q[7:1]};
                            txd_q <= sh_q[1];
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_tc) begin
                        baud_q <= '0;
                        if (pop) begin
                            sh_q    <= head;
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yarvi_uart_tx.sv
// Bench for yarvi_uart_tx: directed frame timing checks plus a randomized
// handshake run decoded by a UART receiver model.
module tb_yarvi_uart_tx;

    localparam int CPB   = 4;
    localparam int CPB2  = 2;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_valid2;
    logic [7:0] in_data, in_data2;
    logic       in_ready, in_ready2;
    logic       txd, txd2;
    logic       busy, busy2;

    int assertions = 0;
    int failures   = 0;

    logic       rx_en = 1'b0;
    logic [7:0] rx_b;
    logic [7:0] rx_q[$];
    logic [7:0] acc_q[$];

    always #5 clk = ~clk;

    yarvi_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(3)) dut (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .txd(txd), .busy(busy)
    );

    yarvi_uart_tx #(.CLKS_PER_BIT(CPB2), .FIFO_LOG2(3)) dut_min (
        .clock(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .txd(txd2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k samples after a frame's first start-bit sample.
    function automatic logic frame_bit(input logic [7:0] b, input int k, input int cpb);
        int s;
        s = k / cpb;
        if (s == 0) return 1'b0;
        if (s >= 9) return 1'b1;
        return b[s-1];
    endfunction

    // UART receiver model: samples each bit at its middle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_en && txd === 1'b0) begin
                repeat (CPB / 2) step();
                assertions++;
                if (txd !== 1'b0) begin
                    failures++;
                    $display("FAIL rx_start_mid: got %b expected 0", txd);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) step();
                    rx_b[i] = txd;
                end
                repeat (CPB) step();
                assertions++;
                if (txd !== 1'b1) begin
                    failures++;
                    $display("FAIL rx_stop_mid: got %b expected 1", txd);
                end
                rx_q.push_back(rx_b);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            step();
            n++;
        end
        assertions++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout: busy=%b expected 0 within 4000 cycles", name, busy);
        end
        repeat (4) step();
    endtask

    task automatic compare_streams(input string name);
        assertions++;
        if (rx_q.size() != acc_q.size()) begin
            failures++;
            $display("FAIL %s_count: decoded %0d bytes expected %0d", name, rx_q.size(), acc_q.size());
        end
        for (int i = 0; i < acc_q.size() && i < rx_q.size(); i++) begin
            assertions++;
            if (rx_q[i] !== acc_q[i]) begin
                failures++;
                $display("FAIL %s_byte%0d: got %h expected %h", name, i, rx_q[i], acc_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_data = 8'h00;
        in_valid2 = 1'b0; in_data2 = 8'h00;
        step();
        step();
        assertions++;
        if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", txd); end
        assertions++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        assertions++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        assertions++;
        if (txd2 !== 1'b1 || busy2 !== 1'b0 || in_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_min: got txd=%b busy=%b rdy=%b expected 1 0 1", txd2, busy2, in_ready2);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [7:0] b;
        b = 8'h55;
        in_data = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        assertions++;
        if (txd !== 1'b1) begin failures++; $display("FAIL single_no_early_start: got %b expected 1", txd); end
        assertions++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_queued: got %b expected 1", busy); end
        step();
        for (int k = 0; k < FRAME; k++) begin
            assertions++;
            if (txd !== frame_bit(b, k, CPB)) begin
                failures++;
                $display("FAIL single_bit k=%0d: got %b expected %b", k, txd, frame_bit(b, k, CPB));
            end
            assertions++;
            if (busy !== 1'b1) begin failures++; $display("FAIL single_busy k=%0d: got %b expected 1", k, busy); end
            step();
        end
        assertions++;
        if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
        for (int k = 0; k < 8; k++) begin
            assertions++;
            if (txd !== 1'b1) begin failures++; $display("FAIL single_idle k=%0d: got %b expected 1", k, txd); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int exp_seq[20];
        exp_seq = '{0,1,1,0,0,0,1,0,1,1, 0,1,1,1,1,0,0,0,0,1};
        in_data = 8'hA3; in_valid = 1'b1;
        step();
        in_data = 8'h0F;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            logic e;
            e = (k < FRAME) ? frame_bit(8'hA3, k, CPB) : frame_bit(8'h0F, k - FRAME, CPB);
            assertions++;
            if (txd !== e) begin
                failures++;
                $display("FAIL b2b_bit k=%0d: got %b expected %b", k, txd, e);
            end
            if ((k % CPB) == CPB / 2) begin
                assertions++;
                if (txd !== exp_seq[k / CPB][0]) begin
                    failures++;
                    $display("FAIL b2b_seq bit=%0d: got %b expected %0d", k / CPB, txd, exp_seq[k / CPB]);
                end
            end
            step();
        end
        assertions++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_drop: got %b expected 0", busy); end
    endtask

    task automatic test_fifo_fill();
        int acc_edge[12];
        int nacc;
        int c;
        logic acc;
        rx_q.delete(); acc_q.delete();
        rx_en = 1'b1;
        nacc = 0;
        c = 0;
        in_data = 8'h10;
        in_valid = 1'b1;
        while (nacc < 12 && c < 600) begin
            if (c == 9) begin
                assertions++;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_low: got %b expected 0", in_ready); end
            end
            acc = in_ready;
            if (acc) begin
                acc_edge[nacc] = c;
                acc_q.push_back(in_data);
                nacc++;
            end
            step();
            c++;
            if (acc) in_data = in_data + 8'd1;
        end
        in_valid = 1'b0;
        assertions++;
        if (nacc != 12) begin failures++; $display("FAIL fill_accept_count: got %0d expected 12", nacc); end
        for (int i = 0; i < nacc; i++) begin
            int e;
            e = (i < 9) ? i : 42 + FRAME * (i - 9);
            assertions++;
            if (acc_edge[i] != e) begin
                failures++;
                $display("FAIL fill_accept_edge i=%0d: got %0d expected %0d", i, acc_edge[i], e);
            end
        end
        wait_idle("fill");
        rx_en = 1'b0;
        compare_streams("fill");
    endtask

    task automatic test_reset_mid_frame();
        logic quiet;
        rx_en = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        assertions++;
        if (txd !== 1'b1) begin failures++; $display("FAIL midrst_txd: got %b expected 1", txd); end
        assertions++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        assertions++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        quiet = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (txd !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        assertions++;
        if (quiet !== 1'b1) begin failures++; $display("FAIL midrst_quiet: got activity expected idle line"); end
        rx_q.delete(); acc_q.delete();
        rx_en = 1'b1;
        in_data = 8'($urandom);
        acc_q.push_back(in_data);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_idle("midrst");
        rx_en = 1'b0;
        compare_streams("midrst");
    endtask

    task automatic test_random();
        int occ;
        int fr;
        int c;
        logic acc;
        rx_q.delete(); acc_q.delete();
        rx_en = 1'b1;
        occ = 0;
        fr = 0;
        c = 0;
        while (acc_q.size() < 200 && c < 20000) begin
            assertions++;
            if (in_ready !== (occ < DEPTH)) begin
                failures++;
                $display("FAIL rand_in_ready c=%0d: got %b expected %b (occupancy %0d)", c, in_ready, occ < DEPTH, occ);
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            acc = in_valid && in_ready;
            if (acc) acc_q.push_back(in_data);
            step();
            c++;
            if (acc) occ++;
            if (fr == 0 && txd === 1'b0) begin
                occ--;
                fr = FRAME - 1;
            end else if (fr > 0) begin
                fr--;
            end
        end
        in_valid = 1'b0;
        assertions++;
        if (acc_q.size() != 200) begin failures++; $display("FAIL rand_accept_count: got %0d expected 200", acc_q.size()); end
        wait_idle("rand");
        rx_en = 1'b0;
        compare_streams("rand");
    endtask

    task automatic test_min_divider();
        in_data2 = 8'h00;
        in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        step();
        for (int k = 0; k < 10 * CPB2; k++) begin
            logic e;
            e = (k >= 9 * CPB2);
            assertions++;
            if (txd2 !== e) begin
                failures++;
                $display("FAIL min_bit k=%0d: got %b expected %b", k, txd2, e);
            end
            step();
        end
        assertions++;
        if (busy2 !== 1'b0 || txd2 !== 1'b1) begin
            failures++;
            $display("FAIL min_end: got busy=%b txd=%b expected 0 1", busy2, txd2);
        end
    endtask

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_data = 8'h00;
        in_valid2 = 1'b0; in_data2 = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_fill();
        test_reset_mid_frame();
        test_random();
        test_min_divider();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/yarvi_uart_tx.md
Name: yarvi_uart_tx

Overview:
Serial transmitter that consumes the 8-bit byte stream yarvi_soc emits on its rx_valid/rx_ready/rx_data port. It buffers bytes in a small FIFO and serialises them as 8N1 UART frames on txd. In the sim toplevel it replaces the constant rx_ready=1 tie-off. On FPGA targets it drives the board's serial pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535
FIFO_LOG2, 3, log2 of FIFO depth (default depth 8)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  byte offered (connects to soc rx_valid)
in_ready  out  1  block accepts byte this cycle (connects to soc rx_ready)
in_data  in  8  byte payload (connects to soc rx_data)
txd  out  1  serial line, idle high
busy  out  1  FIFO non-empty or frame in progress

Behaviour:
- Reset, evaluated on the clock edge:
  - FIFO emptied; state IDLE; bit counter and baud counter 0.
  - txd=1, in_ready=1, busy=0 from the first edge with reset high.
  - Reset mid-frame aborts the frame: txd=1 after that edge, and queued bytes are discarded.
- Handshake:
  - in_ready = !fifo_full. It is a registered-state function with no combinational path from in_valid.
  - Transfer occurs on an edge where in_valid && in_ready; in_data is written at the FIFO tail.
  - in_ready does not anticipate a same-cycle pop: a full FIFO refuses even if a pop happens that edge.
  - Holding in_valid with in_ready low loses nothing.
- FIFO:
  - Depth 2^FIFO_LOG2.
  - Pointers are FIFO_LOG2+1 bits wide and wrap modulo 2^(FIFO_LOG2+1).
  - full = pointers differ only in the MSB; empty = pointers equal.
  - Simultaneous push and pop when non-full: count unchanged, both occur.
- Frame FSM states: IDLE, START, DATA, STOP.
  - IDLE → START: on an edge where the FIFO is non-empty. That edge pops the head into an 8-bit shift register, clears the baud counter, and drives txd=0.
  - Each state lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1, and the terminal count advances the state.
  - START → DATA: txd=sh[0], bit index 0.
  - DATA: at each terminal count, shift right and increment the index. After index 7 completes → STOP with txd=1. Data goes out LSB first.
  - STOP → START: at terminal count if the FIFO is non-empty (pop and load on that same edge, zero idle gap). Otherwise STOP → IDLE.
- Timing:
  - A byte accepted at edge N into an empty FIFO while IDLE is popped at edge N+1, so txd falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have period 10*CLKS_PER_BIT.
- txd is driven from a flop (glitch-free).
- busy = (state != IDLE) || !empty, registered-equivalent.

Test Plan:
1. CLKS_PER_BIT=4. Push 0x55 once after reset.
   - txd falls 1 cycle after acceptance.
   - Each of these levels is held exactly 4 cycles: 0,1,0,1,0,1,0,1,0,1.
   - Then txd stays 1, and busy drops 40 cycles after txd fell.
2. CLKS_PER_BIT=4. Push 0xA3 then 0x0F back-to-back.
   - Sampled bit sequence is 0,1,1,0,0,0,1,0,1,1,0,1,1,1,1,0,0,0,0,1.
   - The second start bit begins exactly 40 cycles after the first; there is no idle high gap.
3. FIFO_LOG2=3, CLKS_PER_BIT=4, in_valid held high from cycle 0.
   - Exactly 9 bytes accepted (8 queued + 1 in shifter), then in_ready=0.
   - in_ready returns to 1 for one acceptance when byte 0's stop bit ends (cycle 41).
   - All bytes appear on txd in order, with no loss or duplication.
4. Reset asserted for 1 cycle during DATA of a frame, with 3 bytes queued.
   - txd=1 and busy=0 after that edge; in_ready=1.
   - No further frames are emitted until a new push.
5. in_valid toggled randomly with random bytes for 200 bytes.
   - A bench UART receiver model decodes a sequence identical to the accepted sequence.
   - in_ready is never 1 while the FIFO is full.
6. CLKS_PER_BIT=2 (minimum).
   - 0x00 gives txd low for 18 cycles, then high for 2.
   - Confirms baud counter terminal-count handling at the minimum divider.
